tb_cmd_scheduler: RTL and testbench

// - Sequences testbench commands onto the SET / WAIT / CHECK / WAIT_DURATION resources.
// - Accepts one decoded command at a time and fires a one-cycle start to exactly one resource.
// - Tracks completion with an optional timeout and returns one status response per command.
// - Sits between the scenario decoder and the injector/event/check/duration blocks.

---
 rtl/tb_cmd_scheduler.sv | 142 ++++++++++++++
 tb/tb_tb_cmd_scheduler.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_cmd_scheduler.sv
// tb_cmd_scheduler: takes one decoded scenario command at a time, fires a
// one-cycle start pulse to the selected resource (SET/WAIT/CHECK/WAIT_DUR),
// tracks completion with an optional cycle timeout and returns one status
// response per command.
// Optional build macro: TB_CMD_SCHED_STATS_EN adds handshake/failure counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// ISSUE | o_start pulse for the latched type; done inputs ignored
// BUSY  | waiting for i_done[type] or timer expiry
// RESP  | rsp_valid high, status held until rsp_ready
module tb_cmd_scheduler #(
  parameter int ALIAS_W = 3,
  parameter int DATA_W  = 32,
  parameter int TMO_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [ALIAS_W-1:0] cmd_alias,
  input  logic [DATA_W-1:0]  cmd_data,
  input  logic [TMO_W-1:0]   cmd_timeout,
  output logic [3:0]         o_start,
  output logic [ALIAS_W-1:0] o_alias,
  output logic [DATA_W-1:0]  o_data,
  input  logic [3:0]         i_done,
  input  logic               i_error,
  output logic               rsp_valid,
  output logic [1:0]         rsp_status,
  input  logic               rsp_ready
`ifdef TB_CMD_SCHED_STATS_EN
  ,
  output logic [15:0]        stat_cmd_cnt,
  output logic [15:0]        stat_fail_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_SET    = 2'd0;
  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_ERROR    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  state_t             state;
  logic [1:0]         typ;
  logic [TMO_W-1:0]   tmo_limit;
  logic [TMO_W-1:0]   timer;
  logic               tmo_en;

  // A zero limit means wait forever; the timer then never moves.
  assign tmo_en = (tmo_limit != '0);

  // Command sequencing FSM with all handshake and resource outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      typ        <= '0;
      tmo_limit  <= '0;
      timer      <= '0;
      cmd_ready  <= 1'b0;
      o_start    <= '0;
      o_alias    <= '0;
      o_data     <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
    end else begin
      o_start <= '0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            typ       <= cmd_type;
            o_alias   <= cmd_alias;
            o_data    <= cmd_data;
            tmo_limit <= cmd_timeout;
            // Loaded here so the first BUSY cycle already sees the full limit.
            timer     <= cmd_timeout;
            o_start   <= 4'b0001 << cmd_type;
            cmd_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (typ == TYPE_SET) begin
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
            state      <= RESP;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: begin
          // Completion is checked before expiry so a done on the last cycle wins.
          if (i_done[typ]) begin
            rsp_valid  <= 1'b1;
            rsp_status <= i_error ? ST_ERROR : ST_OK;
            state      <= RESP;
          end else if (tmo_en && (timer == TMO_W'(1))) begin
            rsp_valid  <= 1'b1;
            rsp_status <= ST_TIMEOUT;
            state      <= RESP;
          end else if (tmo_en) begin
            timer <= timer - TMO_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TB_CMD_SCHED_STATS_EN
  // Saturating counts of response handshakes and of non-OK responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmd_cnt  <= '0;
      stat_fail_cnt <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (stat_cmd_cnt != 16'hFFFF)
        stat_cmd_cnt <= stat_cmd_cnt + 16'd1;
      if ((rsp_status != ST_OK) && (stat_fail_cnt != 16'hFFFF))
        stat_fail_cnt <= stat_fail_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tb_cmd_scheduler.sv
// Bench for tb_cmd_scheduler: directed scenarios with a response scoreboard.
// Build with TB_CMD_SCHED_STATS_EN defined to also cover the stat counters.
module tb_tb_cmd_scheduler;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [2:0]  cmd_alias;
  logic [31:0] cmd_data;
  logic [15:0] cmd_timeout;
  logic [3:0]  o_start;
  logic [2:0]  o_alias;
  logic [31:0] o_data;
  logic [3:0]  i_done;
  logic        i_error;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic        rsp_ready;
`ifdef TB_CMD_SCHED_STATS_EN
  logic [15:0] stat_cmd_cnt;
  logic [15:0] stat_fail_cnt;
  int          exp_cmd_cnt;
  int          exp_fail_cnt;
`endif

  int checks;
  int errors;
  logic [1:0] exp_q[$];

  tb_cmd_scheduler #(.ALIAS_W(3), .DATA_W(32), .TMO_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_type    (cmd_type),
    .cmd_alias   (cmd_alias),
    .cmd_data    (cmd_data),
    .cmd_timeout (cmd_timeout),
    .o_start     (o_start),
    .o_alias     (o_alias),
    .o_data      (o_data),
    .i_done      (i_done),
    .i_error     (i_error),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_ready   (rsp_ready)
`ifdef TB_CMD_SCHED_STATS_EN
    ,
    .stat_cmd_cnt  (stat_cmd_cnt),
    .stat_fail_cnt (stat_fail_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every response handshake pops the expected status.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got status %0d, required no response", rsp_status);
      end else begin
        logic [1:0] exp_s;
        exp_s = exp_q.pop_front();
        if (rsp_status !== exp_s) begin
          errors++;
          $display("FAIL sb_status: got %0d, required %0d", rsp_status, exp_s);
        end
`ifdef TB_CMD_SCHED_STATS_EN
        exp_cmd_cnt++;
        if (exp_s != 2'd0) exp_fail_cnt++;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns in the cycle right after the accept edge.
  task automatic send_cmd(input logic [1:0] t, input logic [2:0] a,
                          input logic [31:0] d, input logic [15:0] tm);
    cmd_type    = t;
    cmd_alias   = a;
    cmd_data    = d;
    cmd_timeout = tm;
    cmd_valid   = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: cmd_ready %b, required 1 within 50 cycles", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: rsp_valid %b cmd_ready %b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({cmd_ready, o_start, o_alias, o_data, rsp_valid, rsp_status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cmd_ready %b o_start %b o_alias %0d o_data %h rsp_valid %b rsp_status %0d, required all 0",
               cmd_ready, o_start, o_alias, o_data, rsp_valid, rsp_status);
    end
    rst_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_pre: cmd_ready %b, required 0", cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_post: cmd_ready %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_set();
    exp_q.push_back(2'd0);
    send_cmd(2'd0, 3'd2, 32'hCAFEDECA, 16'd0);
    checks++;
    if (o_start !== 4'b0001 || o_alias !== 3'd2 || o_data !== 32'hCAFEDECA || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL set_start: o_start %b o_alias %0d o_data %h cmd_ready %b, required 0001 2 cafedeca 0",
               o_start, o_alias, o_data, cmd_ready);
    end
    tick();
    checks++;
    if (o_start !== 4'b0000 || rsp_valid !== 1'b1 || rsp_status !== 2'd0) begin
      errors++;
      $display("FAIL set_rsp: o_start %b rsp_valid %b rsp_status %0d, required 0000 1 0",
               o_start, rsp_valid, rsp_status);
    end
    handshake();
  endtask

  task automatic test_wait_ok();
    logic early;
    early = 1'b0;
    exp_q.push_back(2'd0);
    send_cmd(2'd1, 3'd4, 32'h0000_0011, 16'd10);
    checks++;
    if (o_start !== 4'b0010) begin
      errors++;
      $display("FAIL wait_start: o_start %b, required 0010", o_start);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || o_alias !== 3'd4) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL wait_busy: rsp_valid %b cmd_ready %b o_alias %0d, required 0 0 4", rsp_valid, cmd_ready, o_alias);
    end
    i_done = 4'b0010;
    tick();
    i_done = 4'b0000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'd0) begin
      errors++;
      $display("FAIL wait_rsp: rsp_valid %b rsp_status %0d, required 1 0", rsp_valid, rsp_status);
    end
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold_ready: cmd_ready %b rsp_valid %b, required 0 1", cmd_ready, rsp_valid);
    end
    handshake();
  endtask

  task automatic test_check_error();
    logic early;
    early = 1'b0;
    exp_q.push_back(2'd1);
    send_cmd(2'd2, 3'd1, 32'h5555_AAAA, 16'd0);
    i_done  = 4'b0100;
    i_error = 1'b1;
    tick();
    i_done  = 4'b0000;
    i_error = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL check_issue_done: rsp_valid %b, required 0", rsp_valid);
    end
    for (int i = 0; i < 99; i++) begin
      tick();
      if (rsp_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL check_no_timeout: rsp_valid went 1, required 0 with timeout 0");
    end
    i_done  = 4'b0100;
    i_error = 1'b1;
    tick();
    i_done  = 4'b0000;
    i_error = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'd1) begin
      errors++;
      $display("FAIL check_rsp: rsp_valid %b rsp_status %0d, required 1 1", rsp_valid, rsp_status);
    end
    handshake();
  endtask

  task automatic test_wait_dur_timeout();
    exp_q.push_back(2'd2);
    send_cmd(2'd3, 3'd7, 32'h0000_0004, 16'd4);
    checks++;
    if (o_start !== 4'b1000) begin
      errors++;
      $display("FAIL dur_start: o_start %b, required 1000", o_start);
    end
    tick();
    i_done = 4'b0010;
    tick();
    i_done = 4'b0000;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dur_early: rsp_valid %b after 3 busy cycles, required 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'd2) begin
      errors++;
      $display("FAIL dur_timeout: rsp_valid %b rsp_status %0d, required 1 2", rsp_valid, rsp_status);
    end
    handshake();
  endtask

  task automatic test_done_on_expiry();
    exp_q.push_back(2'd0);
    send_cmd(2'd1, 3'd3, 32'h0000_0003, 16'd3);
    tick();
    tick();
    tick();
    i_done = 4'b0010;
    tick();
    i_done = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_status !== 2'd0) begin
        errors++;
        $display("FAIL expiry_hold_%0d: rsp_valid %b rsp_status %0d, required 1 0", i, rsp_valid, rsp_status);
      end
      tick();
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(2'd0);
    send_cmd(2'd0, 3'd1, 32'hA5A5_A5A5, 16'd0);
    tick();
    cmd_type    = 2'd0;
    cmd_alias   = 3'd6;
    cmd_data    = 32'h0BAD_F00D;
    cmd_timeout = 16'd0;
    cmd_valid   = 1'b1;
    rsp_ready   = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_q.push_back(2'd0);
    checks++;
    if (cmd_ready !== 1'b1 || o_start !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_gap: cmd_ready %b o_start %b, required 1 0000", cmd_ready, o_start);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (o_start !== 4'b0001 || o_alias !== 3'd6 || o_data !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL b2b_second: o_start %b o_alias %0d o_data %h, required 0001 6 0badf00d", o_start, o_alias, o_data);
    end
    tick();
    handshake();
  endtask

  task automatic test_reset_midop();
`ifdef TB_CMD_SCHED_STATS_EN
    checks++;
    if (stat_cmd_cnt !== 16'(exp_cmd_cnt) || stat_fail_cnt !== 16'(exp_fail_cnt)) begin
      errors++;
      $display("FAIL stats_pre: cmd %0d fail %0d, required %0d %0d", stat_cmd_cnt, stat_fail_cnt, exp_cmd_cnt, exp_fail_cnt);
    end
`endif
    send_cmd(2'd1, 3'd5, 32'h1234_5678, 16'd0);
    tick();
    tick();
    rst_n = 1'b0;
`ifdef TB_CMD_SCHED_STATS_EN
    exp_cmd_cnt  = 0;
    exp_fail_cnt = 0;
`endif
    #1;
    checks++;
    if ({cmd_ready, o_start, o_alias, o_data, rsp_valid, rsp_status} !== '0) begin
      errors++;
      $display("FAIL midop_reset: cmd_ready %b o_start %b o_alias %0d o_data %h rsp_valid %b rsp_status %0d, required all 0",
               cmd_ready, o_start, o_alias, o_data, rsp_valid, rsp_status);
    end
`ifdef TB_CMD_SCHED_STATS_EN
    checks++;
    if (stat_cmd_cnt !== 16'd0 || stat_fail_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: cmd %0d fail %0d, required 0 0", stat_cmd_cnt, stat_fail_cnt);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_recover: cmd_ready %b rsp_valid %b, required 1 0", cmd_ready, rsp_valid);
    end
    exp_q.push_back(2'd0);
    send_cmd(2'd0, 3'd0, 32'hFEED_BEEF, 16'd0);
    checks++;
    if (o_start !== 4'b0001 || o_data !== 32'hFEED_BEEF) begin
      errors++;
      $display("FAIL midop_next: o_start %b o_data %h, required 0001 feedbeef", o_start, o_data);
    end
    tick();
    handshake();
`ifdef TB_CMD_SCHED_STATS_EN
    checks++;
    if (stat_cmd_cnt !== 16'd1 || stat_fail_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_post: cmd %0d fail %0d, required 1 0", stat_cmd_cnt, stat_fail_cnt);
    end
`endif
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_type    = 2'd0;
    cmd_alias   = 3'd0;
    cmd_data    = 32'd0;
    cmd_timeout = 16'd0;
    i_done      = 4'b0000;
    i_error     = 1'b0;
    rsp_ready   = 1'b0;
`ifdef TB_CMD_SCHED_STATS_EN
    exp_cmd_cnt  = 0;
    exp_fail_cnt = 0;
`endif
    test_reset();
    test_set();
    test_wait_ok();
    test_check_error();
    test_wait_dur_timeout();
    test_done_on_expiry();
    test_back_to_back();
    test_reset_midop();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d responses missing, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
